// File: rtl/serial_shift_unit.sv
// rtl/serial_shift_unit.sv - multi-cycle one-bit-per-clock shifter with start/busy/done handshake
module serial_shift_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] Shift_In,
    input  logic [CNT_W-1:0] Shift_Val,
    input  logic [1:0]       Mode,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Shift_Out,
    output logic             Carry_Out,
    output logic             Zero
);

    localparam logic [1:0] MODE_SRL = 2'b00;
    localparam logic [1:0] MODE_ROL = 2'b01;
    localparam logic [1:0] MODE_SLL = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   work;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         mode_q;
    logic [WIDTH-1:0]   shifted;
    logic               shift_carry;
    logic               last_shift;

    // The final shift is the one taken while the counter still reads one.
    assign last_shift = (cnt == CNT_W'(1));

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; Start is only looked at while idle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    state_next = (Shift_Val != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (last_shift) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // One-bit shift of the work register and the bit that leaves it.
    always_comb begin
        shifted     = work;
        shift_carry = 1'b0;
        case (mode_q)
            MODE_SRL: begin
                shifted     = {1'b0, work[WIDTH-1:1]};
                shift_carry = work[0];
            end
            MODE_ROL: begin
                shifted     = {work[WIDTH-2:0], work[WIDTH-1]};
                shift_carry = work[WIDTH-1];
            end
            MODE_SLL: begin
                shifted     = {work[WIDTH-2:0], 1'b0};
                shift_carry = work[WIDTH-1];
            end
            MODE_ROR: begin
                shifted     = {work[0], work[WIDTH-1:1]};
                shift_carry = work[0];
            end
            default: begin
                shifted     = work;
                shift_carry = 1'b0;
            end
        endcase
    end

    // Operand capture, per-cycle shifting, and result load on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            work      <= '0;
            cnt       <= '0;
            mode_q    <= MODE_SRL;
            Shift_Out <= '0;
            Carry_Out <= 1'b0;
            Zero      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        work   <= Shift_In;
                        cnt    <= Shift_Val;
                        mode_q <= Mode;
                        // A zero-length shift goes straight to DONE with the operand unchanged.
                        if (Shift_Val == '0) begin
                            Shift_Out <= Shift_In;
                            Carry_Out <= 1'b0;
                            Zero      <= (Shift_In == '0);
                        end
                    end
                end
                ST_SHIFT: begin
                    work <= shifted;
                    cnt  <= cnt - CNT_W'(1);
                    if (last_shift) begin
                        Shift_Out <= shifted;
                        Carry_Out <= shift_carry;
                        Zero      <= (shifted == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Busy = (state != ST_IDLE);
    assign Done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_shift_unit.sv
// tb/tb_serial_shift_unit.sv - randomized self-checking bench for serial_shift_unit
module tb_serial_shift_unit;

    logic        clk;
    logic        rst;
    logic        Start;
    logic [15:0] Shift_In;
    logic [3:0]  Shift_Val;
    logic [1:0]  Mode;
    logic        Busy;
    logic        Done;
    logic [15:0] Shift_Out;
    logic        Carry_Out;
    logic        Zero;

    int checks;
    int errors;

    logic [15:0] prev_out;
    logic        prev_c;
    logic        prev_z;

    serial_shift_unit dut (
        .clk       (clk),
        .rst       (rst),
        .Start     (Start),
        .Shift_In  (Shift_In),
        .Shift_Val (Shift_Val),
        .Mode      (Mode),
        .Busy      (Busy),
        .Done      (Done),
        .Shift_Out (Shift_Out),
        .Carry_Out (Carry_Out),
        .Zero      (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole shift by n computed arithmetically.
    task automatic model(input logic [1:0] m, input logic [15:0] x, input int n,
                         output logic [15:0] r, output logic c);
        logic [31:0] xx;
        logic [31:0] t;
        xx = {16'h0, x};
        case (m)
            2'b00: begin t = xx >> n;                         c = (n == 0) ? 1'b0 : xx[n-1]; end
            2'b10: begin t = (xx << n) & 32'hFFFF;            c = (n == 0) ? 1'b0 : xx[16-n]; end
            2'b01: begin t = ((xx << n) | (xx >> (16 - n))) & 32'hFFFF; c = (n == 0) ? 1'b0 : t[0]; end
            default: begin t = ((xx >> n) | (xx << (16 - n))) & 32'hFFFF; c = (n == 0) ? 1'b0 : t[15]; end
        endcase
        r = t[15:0];
    endtask

    // Issue one operation, optionally pulsing Start with junk while busy, and check everything.
    task automatic run_op(input logic [1:0] m, input logic [15:0] x, input int n, input bit noise);
        logic [15:0] er;
        logic        ec;
        int          k;
        bit          seen;
        model(m, x, n, er, ec);
        @(negedge clk);
        Start = 1'b1; Shift_In = x; Shift_Val = 4'(n); Mode = m;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            Start = 1'b0;
            Shift_In = 16'($urandom); Shift_Val = 4'($urandom); Mode = 2'($urandom);
            check("busy", 32'(Busy), 32'd1);
            if (Done) begin
                seen = 1'b1;
            end else begin
                check("hold_out", 32'(Shift_Out), 32'(prev_out));
                check("hold_flags", {30'd0, Carry_Out, Zero}, {30'd0, prev_c, prev_z});
                if (noise) Start = 1'($urandom);
            end
        end
        Start = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(k), 32'(n + 1));
        check("shift_out", 32'(Shift_Out), 32'(er));
        check("carry_out", 32'(Carry_Out), 32'(ec));
        check("zero", 32'(Zero), 32'(er == 16'h0));
        prev_out = er; prev_c = ec; prev_z = (er == 16'h0);
        @(negedge clk);
        check("idle_busy", 32'(Busy), 32'd0);
        check("idle_done", 32'(Done), 32'd0);
    endtask

    initial begin
        int ndone;
        checks = 0; errors = 0;
        prev_out = '0; prev_c = 1'b0; prev_z = 1'b0;
        rst = 1'b1; Start = 1'b0; Shift_In = '0; Shift_Val = '0; Mode = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_out", 32'(Shift_Out), 32'd0);
        check("rst_flags", {30'd0, Carry_Out, Zero}, 32'd0);

        run_op(2'b00, 16'h800F, 4, 1'b0);
        run_op(2'b01, 16'h8001, 1, 1'b0);
        run_op(2'b10, 16'h0001, 15, 1'b1);
        run_op(2'b11, 16'h1234, 0, 1'b0);
        run_op(2'b00, 16'h0001, 1, 1'b0);
        run_op(2'b01, 16'hF000, 4, 1'b0);

        // Reset mid-operation: result cleared, no Done afterwards.
        @(negedge clk);
        Start = 1'b1; Shift_In = 16'hFFFF; Shift_Val = 4'd8; Mode = 2'b10;
        @(negedge clk);
        Start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(Busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mr_busy", 32'(Busy), 32'd0);
        check("mr_out", 32'(Shift_Out), 32'd0);
        check("mr_flags", {30'd0, Carry_Out, Zero}, 32'd0);
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (Done) ndone++;
        end
        check("mr_no_done", 32'(ndone), 32'd0);
        prev_out = '0; prev_c = 1'b0; prev_z = 1'b0;
        run_op(2'b10, 16'h00F0, 3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom), 16'($urandom), int'($urandom_range(0, 15)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
